spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 26 ++
 rtl/spi_peripheral.sv | 157 +++++++++++++++
 tb/tb_spi_peripheral.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
// Shared defaults and FSM state encoding for the SPI peripheral.
package spi_pkg;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// Multi-flop synchronizer for one asynchronous input plus an edge detector
// that compares the last synchronizer stage with one extra delay flop.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic level,
    output logic rise,
    output logic fall
);
    // [STAGES-1:0] synchronize, [STAGES] is the delay flop for edge detection
    logic [STAGES:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) sync_q <= {(STAGES+1){RST_VAL}};
        else          sync_q <= {sync_q[STAGES-1:0], i_async};
    end

    assign level = sync_q[STAGES-1];
    assign rise  =  sync_q[STAGES-1] & ~sync_q[STAGES];
    assign fall  = ~sync_q[STAGES-1] &  sync_q[STAGES];
endmodule

// File: rtl/spi_peripheral.sv
`timescale 1ns/1ps
// SPI mode-0 peripheral, MSB first, oversampled by i_clk, with a one-entry
// transmit holding buffer and back-to-back byte support inside one frame.
import spi_pkg::*;

module spi_peripheral #(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_en,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_tx_underrun
);
    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam int              NSIG     = 3;
    localparam logic [NSIG-1:0] SYNC_RST = 3'b010;  // {mosi, cs_n, sclk}

    logic [NSIG-1:0] sig_async, sig_level, sig_rise, sig_fall;
    assign sig_async = {i_mosi, i_cs_n, i_sclk};

    for (genvar g = 0; g < NSIG; g++) begin : g_sync
        spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[g])) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_async (sig_async[g]),
            .level   (sig_level[g]),
            .rise    (sig_rise[g]),
            .fall    (sig_fall[g])
        );
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_level, mosi_s;
    assign sclk_rise = sig_rise[0];
    assign sclk_fall = sig_fall[0];
    assign cs_rise   = sig_rise[1];
    assign cs_fall   = sig_fall[1];
    assign cs_level  = sig_level[1];
    assign mosi_s    = sig_level[2];

    logic unused_sync;
    assign unused_sync = ^{sig_level[0], sig_rise[2], sig_fall[2]};

    spi_state_t            state_q, state_d;
    logic [SYNC_STAGES:0]  flush_pipe;
    logic                  armed_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_shift_q, tx_shift_q, hold_q;
    logic                  tx_ready_q, wrap_q, underrun_pend_q;
    logic                  start, stop, bit_rise, bit_fall, wrap, load_tx;

    // Synchronizer reset values fake a cs_n fall if cs_n is low at reset
    // release; a frame may only start once cs_n has been seen high afterwards.
    assign start    = (state_q == IDLE) && armed_q && cs_fall;
    assign stop     = (state_q == ACTIVE) && cs_rise;
    assign bit_rise = (state_q == ACTIVE) && !cs_rise && sclk_rise;
    assign bit_fall = (state_q == ACTIVE) && !cs_rise && sclk_fall;
    assign wrap     = bit_rise && (bit_cnt_q == LAST_BIT);
    assign load_tx  = start || wrap;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACTIVE;
            ACTIVE:  if (stop)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            flush_pipe <= '0;
            armed_q    <= 1'b0;
        end else begin
            flush_pipe <= {flush_pipe[SYNC_STAGES-1:0], 1'b1};
            if (flush_pipe[SYNC_STAGES] && cs_level) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bit_cnt_q       <= '0;
            rx_shift_q      <= '0;
            tx_shift_q      <= '0;
            hold_q          <= '0;
            tx_ready_q      <= 1'b1;
            wrap_q          <= 1'b0;
            underrun_pend_q <= 1'b0;
            o_rx_data       <= '0;
            o_rx_valid      <= 1'b0;
            o_tx_underrun   <= 1'b0;
        end else begin
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;

            // Copy one cycle after the final shift so o_rx_data sees the full byte
            wrap_q <= wrap;
            if (wrap_q) begin
                o_rx_data  <= rx_shift_q;
                o_rx_valid <= 1'b1;
            end

            if (stop) begin
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end else if (bit_rise) begin
                rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                bit_cnt_q  <= wrap ? '0 : bit_cnt_q + 1'b1;
            end

            if (load_tx)
                tx_shift_q <= tx_ready_q ? '0 : hold_q;
            else if (stop)
                tx_shift_q <= '0;
            else if (bit_fall && bit_cnt_q != '0)
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};

            // A slot loaded empty at a wrap only counts once the controller
            // actually clocks into it; at frame start it counts immediately.
            if (start && tx_ready_q) o_tx_underrun <= 1'b1;
            if (stop) begin
                underrun_pend_q <= 1'b0;
            end else if (wrap) begin
                underrun_pend_q <= tx_ready_q;
            end else if (bit_rise && bit_cnt_q == '0 && underrun_pend_q) begin
                o_tx_underrun   <= 1'b1;
                underrun_pend_q <= 1'b0;
            end

            if (load_tx && !tx_ready_q) begin
                tx_ready_q <= 1'b1;
            end else if (i_tx_valid && tx_ready_q) begin
                hold_q     <= i_tx_data;
                tx_ready_q <= 1'b0;
            end
        end
    end

    assign o_tx_ready = tx_ready_q;
    assign o_miso_en  = (state_q == ACTIVE);
    assign o_miso     = (state_q == ACTIVE) & tx_shift_q[DATA_WIDTH-1];
endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
// Directed bench: 40 MHz i_clk, 5 MHz SCLK, table of single-byte frames plus
// hand sequences; received bytes are checked through an expected-value queue.
module tb_spi_peripheral;
    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi;
    logic       o_miso, o_miso_en, o_tx_ready, o_rx_valid, o_tx_underrun;
    logic [7:0] tx_data, o_rx_data;
    logic       tx_valid;

    int n_checks = 0, n_fail = 0;
    int rx_pulses = 0, underruns = 0;
    bit en_seen = 1'b0;
    logic [7:0] exp_q[$];

    spi_peripheral dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sclk        (sclk),
        .i_cs_n        (cs_n),
        .i_mosi        (mosi),
        .o_miso        (o_miso),
        .o_miso_en     (o_miso_en),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (o_tx_ready),
        .o_rx_data     (o_rx_data),
        .o_rx_valid    (o_rx_valid),
        .o_tx_underrun (o_tx_underrun)
    );

    always #12.5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every o_rx_valid cycle must match the next queued byte
    always @(posedge clk) begin
        #1;
        if (o_rx_valid) begin
            rx_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got 0x%0h expected no pulse", o_rx_data);
            end else begin
                check("rx_data_sb", 32'(o_rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (o_tx_underrun) underruns++;
        if (o_miso_en) en_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] d);
        int t = 0;
        while (!o_tx_ready && t < 200) begin tick(1); t++; end
        check("preload_ready", 32'(o_tx_ready), 32'd1);
        tx_data = d; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check("ready_low_after_write", 32'(o_tx_ready), 32'd0);
    endtask

    task automatic cs_low();
        cs_n = 1'b0; tick(4);
    endtask

    task automatic cs_high();
        tick(4); cs_n = 1'b1; tick(6);
    endtask

    // Mode 0: controller drives MOSI while SCLK is low and samples MISO at the rise
    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            tick(4);
            mi = {mi[6:0], o_miso};
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    typedef struct {
        logic       pre;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] miso;
        int         un;
    } vec_t;

    initial begin
        vec_t tbl[4];
        logic [7:0] mi, mi2;
        int p0, u0, lat;

        tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
        tbl[1] = '{1'b0, 8'h00, 8'h2B, 8'h00, 1};
        tbl[2] = '{1'b1, 8'hC3, 8'hF0, 8'hC3, 0};
        tbl[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 0};

        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        tick(3);
        check("rst_miso",     32'(o_miso),        32'd0);
        check("rst_miso_en",  32'(o_miso_en),     32'd0);
        check("rst_tx_ready", 32'(o_tx_ready),    32'd1);
        check("rst_rx_data",  32'(o_rx_data),     32'd0);
        check("rst_rx_valid", 32'(o_rx_valid),    32'd0);
        check("rst_underrun", 32'(o_tx_underrun), 32'd0);
        rst_n = 1'b1;
        tick(10);

        foreach (tbl[v]) begin
            p0 = rx_pulses; u0 = underruns;
            if (tbl[v].pre) preload(tbl[v].tx);
            exp_q.push_back(tbl[v].mo);
            cs_low();
            check("miso_en_active", 32'(o_miso_en), 32'd1);
            xfer_bits(tbl[v].mo, 8, mi);
            cs_high();
            check("miso_bits",   32'(mi),            32'(tbl[v].miso));
            check("underruns",   32'(underruns - u0), 32'(tbl[v].un));
            check("rx_pulses",   32'(rx_pulses - p0), 32'd1);
            check("rx_data",     32'(o_rx_data),     32'(tbl[v].mo));
            check("tx_ready_end", 32'(o_tx_ready),   32'd1);
            check("miso_idle",   32'(o_miso),        32'd0);
            check("miso_en_idle", 32'(o_miso_en),    32'd0);
        end

        // Back-to-back bytes; second byte written once the first is consumed
        p0 = rx_pulses; u0 = underruns;
        preload(8'h01);
        exp_q.push_back(8'h63);
        exp_q.push_back(8'h6B);
        cs_low();
        check("b2b_ready_rise", 32'(o_tx_ready), 32'd1);
        preload(8'h02);
        xfer_bits(8'h63, 8, mi);
        xfer_bits(8'h6B, 8, mi2);
        cs_high();
        check("b2b_miso0",     32'(mi),              32'h01);
        check("b2b_miso1",     32'(mi2),             32'h02);
        check("b2b_rx_pulses", 32'(rx_pulses - p0),  32'd2);
        check("b2b_underrun",  32'(underruns - u0),  32'd0);
        check("b2b_rx_data",   32'(o_rx_data),       32'h6B);

        // Abort after 5 bits, then a clean frame
        p0 = rx_pulses;
        cs_low();
        xfer_bits(8'hFF, 5, mi);
        cs_high();
        check("abort_no_pulse", 32'(rx_pulses - p0), 32'd0);
        check("abort_rx_hold",  32'(o_rx_data),       32'h6B);
        exp_q.push_back(8'h06);
        cs_low();
        xfer_bits(8'h06, 8, mi);
        cs_high();
        check("after_abort_rx", 32'(o_rx_data), 32'h06);

        // Reset mid-frame: cs_n stays low afterwards, frame needs a fresh fall
        preload(8'h81);
        cs_low();
        xfer_bits(8'hAA, 3, mi);
        rst_n = 1'b0;
        tick(2);
        check("mrst_miso",     32'(o_miso),        32'd0);
        check("mrst_miso_en",  32'(o_miso_en),     32'd0);
        check("mrst_tx_ready", 32'(o_tx_ready),    32'd1);
        check("mrst_rx_data",  32'(o_rx_data),     32'd0);
        check("mrst_rx_valid", 32'(o_rx_valid),    32'd0);
        check("mrst_underrun", 32'(o_tx_underrun), 32'd0);
        rst_n = 1'b1;
        tick(6);
        p0 = rx_pulses; en_seen = 1'b0;
        xfer_bits(8'h55, 8, mi);
        check("mrst_no_pulse", 32'(rx_pulses - p0), 32'd0);
        check("mrst_no_en",    32'(en_seen),        32'd0);
        cs_high();
        exp_q.push_back(8'h77);
        cs_low();
        xfer_bits(8'h77, 8, mi);
        cs_high();
        check("mrst_next_rx", 32'(o_rx_data), 32'h77);

        // Idle SCLK noise with cs_n high
        p0 = rx_pulses; en_seen = 1'b0;
        xfer_bits(8'hFF, 8, mi);
        xfer_bits(8'h5A, 8, mi);
        tick(6);
        check("idle_no_pulse", 32'(rx_pulses - p0), 32'd0);
        check("idle_no_en",    32'(en_seen),        32'd0);

        // o_rx_valid latency from the final SCLK rise
        exp_q.push_back(8'h9E);
        cs_low();
        xfer_bits(8'h9E, 7, mi);
        mosi = 1'b0;
        tick(4);
        sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (o_rx_valid) lat = k;
        end
        check("rx_latency", 32'(lat), 32'd4);
        tick(4);
        sclk = 1'b0;
        cs_high();
        check("latency_rx", 32'(o_rx_data), 32'h9E);

        tick(4);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
